swipt_frame_rx: RTL and testbench

SWIPT_FRAME_RX -- requirements
Module: swipt_frame_rx

---
 rtl/swipt_frame_rx.sv | 153 +++++++++++++++
 tb/tb_swipt_frame_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/swipt_frame_rx.sv
// SWIPT downlink frame receiver: 36-bit MSB-first frame, mid-bit sampling, field checks.
// Optional macro SWIPT_FRAME_RX_RESYNC_EN re-centres the sample point on every din edge in SHIFT.
module swipt_frame_rx #(
    parameter int BIT_PERIOD = 200000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rx_en,
    input  logic        din,
    output logic [1:0]  rx_mode,
    output logic [1:0]  rx_type,
    output logic [15:0] rx_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy
);
    localparam logic [19:0] HALF_LOAD = 20'(BIT_PERIOD / 2 - 1);
    localparam logic [19:0] FULL_LOAD = 20'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, CHECK} state_t;

    state_t      state;
    logic        din_s1;
    logic        din_s2;
    logic        din_prev;
    logic [19:0] cnt;
    logic [5:0]  bit_idx;
    logic [35:0] shreg;

    logic [5:0]  f_pre;
    logic [7:0]  f_pairs;
    logic [15:0] f_data;
    logic [1:0]  f_par;
    logic [3:0]  f_trl;
    logic        pairs_ok;
    logic [2:0]  check_code;

    // din_prev keeps running in every state so IDLE only reacts to a fresh 0->1 edge
    always_ff @(posedge clk) begin
        if (!nrst) begin
            din_s1   <= 1'b0;
            din_s2   <= 1'b0;
            din_prev <= 1'b0;
        end else begin
            din_s1   <= din;
            din_s2   <= din_s1;
            din_prev <= din_s2;
        end
    end

    assign f_pre    = shreg[35:30];
    assign f_pairs  = shreg[29:22];
    assign f_data   = shreg[21:6];
    assign f_par    = shreg[5:4];
    assign f_trl    = shreg[3:0];
    assign pairs_ok = (f_pairs[7] ^ f_pairs[6]) & (f_pairs[5] ^ f_pairs[4]) &
                      (f_pairs[3] ^ f_pairs[2]) & (f_pairs[1] ^ f_pairs[0]);

    // Checks in priority order; zero means the frame is good
    always_comb begin
        check_code = 3'b000;
        if (f_pre != 6'b101010)
            check_code = 3'b001;
        else if (!pairs_ok)
            check_code = 3'b010;
        else if (f_par != {~^f_data, ^f_data})
            check_code = 3'b011;
        else if (f_trl != 4'b0101)
            check_code = 3'b100;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= 20'd0;
            bit_idx     <= 6'd35;
            shreg       <= 36'd0;
            rx_mode     <= 2'b00;
            rx_type     <= 2'b00;
            rx_data     <= 16'h0000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 3'b000;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (!rx_en) begin
                state   <= IDLE;
                cnt     <= 20'd0;
                bit_idx <= 6'd35;
                shreg   <= 36'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (din_s2 && !din_prev) begin
                            state <= ALIGN;
                            cnt   <= HALF_LOAD;
                        end
                    end
                    ALIGN: begin
                        if (cnt == 20'd0) begin
                            shreg   <= {shreg[34:0], din_s2};
                            cnt     <= FULL_LOAD;
                            bit_idx <= 6'd34;
                            state   <= SHIFT;
                        end else begin
                            cnt <= cnt - 20'd1;
                        end
                    end
                    SHIFT: begin
                        if (cnt == 20'd0) begin
                            shreg <= {shreg[34:0], din_s2};
                            if (bit_idx == 6'd0) begin
                                state <= CHECK;
                            end else begin
                                bit_idx <= bit_idx - 6'd1;
                                cnt     <= FULL_LOAD;
                            end
                        end else begin
`ifdef SWIPT_FRAME_RX_RESYNC_EN
                            if (din_s2 != din_prev)
                                cnt <= HALF_LOAD;
                            else
                                cnt <= cnt - 20'd1;
`else
                            cnt <= cnt - 20'd1;
`endif
                        end
                    end
                    CHECK: begin
                        if (check_code == 3'b000) begin
                            frame_valid <= 1'b1;
                            rx_mode     <= {f_pairs[6], f_pairs[4]};
                            rx_type     <= {f_pairs[2], f_pairs[0]};
                            rx_data     <= f_data;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= check_code;
                        end
                        state   <= IDLE;
                        cnt     <= 20'd0;
                        bit_idx <= 6'd35;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_swipt_frame_rx.sv
// Self-checking bench for swipt_frame_rx at BIT_PERIOD=16: frame-level model plus literal pins.
module tb_swipt_frame_rx;
    localparam int BP        = 16;
    localparam int PULSE_OFS = 3 + BP / 2 + 35 * BP + 1;
    localparam logic [35:0] F0 = 36'hA966970E5;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rx_en = 1'b1;
    logic        din = 1'b0;
    logic [1:0]  rx_mode;
    logic [1:0]  rx_type;
    logic [15:0] rx_data;
    logic        frame_valid;
    logic        frame_err;
    logic [2:0]  err_code;
    logic        busy;

    swipt_frame_rx #(.BIT_PERIOD(BP)) dut (
        .clk(clk), .nrst(nrst), .rx_en(rx_en), .din(din),
        .rx_mode(rx_mode), .rx_type(rx_type), .rx_data(rx_data),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_seen = 1'b1;
    always @(posedge clk) rst_seen <= !nrst;

    // Expectations posted by the stimulus process, consumed by the compare process
    int          exp_seq = 0;
    int          exp_at, exp_lo, exp_hi;
    bit          exp_window, exp_valid;
    logic [2:0]  exp_code;
    logic [1:0]  exp_mode, exp_type;
    logic [15:0] exp_data;
    int          busy_lo = -1, busy_hi = -1;
    bit          busy_known = 1'b1;
    int          pin_seq = 0, pin_sel = 0;
    logic [31:0] pin_val = 32'd0;
    string       pin_name = "";

    int          done_seq = 0, pin_done = 0;
    int          cmp_count = 0, fail_count = 0;
    int          valid_pulses = 0, err_pulses = 0;
    logic [1:0]  m_mode = 2'b00, m_type = 2'b00;
    logic [15:0] m_data = 16'h0000;
    logic [2:0]  m_code = 3'b000;
    logic [31:0] pin_act;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_count++;
        if (act !== req) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            m_mode = 2'b00; m_type = 2'b00; m_data = 16'h0000; m_code = 3'b000;
        end
        checkOutput("exclusive", 32'(frame_valid & frame_err), 32'd0);
        if (exp_seq != done_seq) begin
            if ((!exp_window && cyc == exp_at) ||
                (exp_window && (frame_valid || frame_err) && cyc >= exp_lo && cyc <= exp_hi)) begin
                checkOutput("pulse_valid", 32'(frame_valid), 32'(exp_valid));
                checkOutput("pulse_err", 32'(frame_err), 32'(!exp_valid));
                if (exp_valid) begin
                    m_mode = exp_mode; m_type = exp_type; m_data = exp_data;
                end else begin
                    m_code = exp_code;
                end
                done_seq = exp_seq;
            end else begin
                checkOutput("early_pulse", 32'({frame_valid, frame_err}), 32'd0);
                if (exp_window && cyc > exp_hi) begin
                    cmp_count++;
                    fail_count++;
                    $display("[TB] FAIL pulse_timeout: got none, want pulse by cycle %0d", exp_hi);
                    done_seq = exp_seq;
                end
            end
        end else begin
            checkOutput("stray_pulse", 32'({frame_valid, frame_err}), 32'd0);
        end
        if (frame_valid) valid_pulses++;
        if (frame_err) err_pulses++;
        checkOutput("rx_mode", 32'(rx_mode), 32'(m_mode));
        checkOutput("rx_type", 32'(rx_type), 32'(m_type));
        checkOutput("rx_data", 32'(rx_data), 32'(m_data));
        checkOutput("err_code", 32'(err_code), 32'(m_code));
        if (busy_known)
            checkOutput("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        if (pin_seq != pin_done) begin
            case (pin_sel)
                0: pin_act = 32'(rx_data);
                1: pin_act = 32'(err_code);
                2: pin_act = 32'(rx_mode);
                3: pin_act = 32'(rx_type);
                4: pin_act = 32'(valid_pulses);
                5: pin_act = 32'(busy);
                6: pin_act = 32'(err_pulses);
                default: pin_act = 32'({frame_valid, frame_err});
            endcase
            checkOutput(pin_name, pin_act, pin_val);
            pin_done = pin_seq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectLiteral(input int sel, input logic [31:0] val, input string name);
        pin_sel = sel; pin_val = val; pin_name = name;
        pin_seq++;
        tick();
    endtask

    function automatic logic [35:0] buildFrame(input logic [1:0] md, input logic [1:0] ty, input logic [15:0] d);
        return {6'b101010, ~md[1], md[1], ~md[0], md[0], ~ty[1], ty[1], ~ty[0], ty[0], d, ~^d, ^d, 4'b0101};
    endfunction

    // Which line bit each of the 36 samples lands on, then the frame rules on those samples
    function automatic void predict(input logic [35:0] f, input int lp, output bit ok, output logic [2:0] code,
                                    output logic [1:0] md, output logic [1:0] ty, output logic [15:0] dt);
        bit s[36];
        int ones;
        bit pre_ok, pair_ok;
        for (int n = 0; n < 36; n++) begin
            int j;
`ifdef SWIPT_FRAME_RX_RESYNC_EN
            j = n;
`else
            j = (BP / 2 + n * BP) / lp;
`endif
            s[n] = (j < 36) ? f[35 - j] : 1'b0;
        end
        pre_ok = (s[0] && !s[1] && s[2] && !s[3] && s[4] && !s[5]);
        pair_ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (s[6 + 2 * i] == s[7 + 2 * i]) pair_ok = 1'b0;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            dt[15 - i] = s[14 + i];
            if (s[14 + i]) ones++;
        end
        md = {s[7], s[9]};
        ty = {s[11], s[13]};
        if (!pre_ok) code = 3'd1;
        else if (!pair_ok) code = 3'd2;
        else if (s[30] != (ones % 2 == 0) || s[31] != (ones % 2 == 1)) code = 3'd3;
        else if (s[32] || !s[33] || s[34] || !s[35]) code = 3'd4;
        else code = 3'd0;
        ok = (code == 3'd0);
    endfunction

    task automatic applyStimulus(input logic [35:0] f, input int lp, input int abort_bit, input bit by_reset);
        int k;
        bit ok;
        logic [2:0] code;
        logic [1:0] md, ty;
        logic [15:0] dt;
        predict(f, lp, ok, code, md, ty, dt);
        k = cyc;
        if (abort_bit < 0 || abort_bit * lp > PULSE_OFS) begin
            exp_valid = ok; exp_code = code; exp_mode = md; exp_type = ty; exp_data = dt;
`ifdef SWIPT_FRAME_RX_RESYNC_EN
            exp_window = (lp != BP);
`else
            exp_window = 1'b0;
`endif
            exp_at = k + PULSE_OFS;
            exp_lo = k + 35 * lp;
            exp_hi = k + 36 * lp + BP;
            busy_lo = k + 3;
            busy_hi = k + PULSE_OFS - 1;
            busy_known = !exp_window;
            exp_seq++;
        end else begin
            busy_known = 1'b0;
        end
        for (int b = 0; b < 36; b++) begin
            if (b == abort_bit) begin
                if (by_reset) nrst = 1'b0;
                else rx_en = 1'b0;
            end
            din = f[35 - b];
            repeat (lp) tick();
        end
        din = 1'b0;
        repeat (2 * BP) tick();
        rx_en = 1'b1;
        nrst = 1'b1;
        busy_known = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        expectLiteral(0, 32'h0, "rst_rx_data");
        expectLiteral(1, 32'h0, "rst_err_code");
        expectLiteral(2, 32'h0, "rst_rx_mode");
        expectLiteral(5, 32'h0, "rst_busy");
        expectLiteral(7, 32'h0, "rst_pulses");
        nrst = 1'b1;
        repeat (2 * BP) tick();

        applyStimulus(F0, BP, -1, 1'b0);
        expectLiteral(0, 32'hA5C3, "v1_data");
        expectLiteral(2, 32'h3, "v1_mode");
        expectLiteral(3, 32'h1, "v1_type");
        expectLiteral(4, 32'd1, "v1_count");

        applyStimulus(F0 ^ (36'h1 << 6), BP, -1, 1'b0);
        expectLiteral(1, 32'h3, "parity_code");
        expectLiteral(0, 32'hA5C3, "parity_data_kept");
        applyStimulus(F0 ^ (36'h1 << 30), BP, -1, 1'b0);
        expectLiteral(1, 32'h1, "preamble_code");
        applyStimulus(F0 ^ (36'h1 << 29), BP, -1, 1'b0);
        expectLiteral(1, 32'h2, "pair_code");
        applyStimulus(F0 ^ (36'h1 << 1), BP, -1, 1'b0);
        expectLiteral(1, 32'h4, "trailer_code");
        expectLiteral(6, 32'd4, "err_count");

        applyStimulus(F0, BP, 20, 1'b0);
        expectLiteral(4, 32'd1, "abort_no_pulse");
        applyStimulus(buildFrame(2'b10, 2'b11, 16'h1234), BP, -1, 1'b0);
        expectLiteral(0, 32'h1234, "after_abort_data");
        expectLiteral(4, 32'd2, "after_abort_count");

        applyStimulus(buildFrame(2'b00, 2'b00, 16'h0001), BP, -1, 1'b0);
        expectLiteral(0, 32'h0001, "b2b_first_data");
        applyStimulus(buildFrame(2'b01, 2'b10, 16'hFFFE), BP, -1, 1'b0);
        expectLiteral(0, 32'hFFFE, "b2b_second_data");
        expectLiteral(4, 32'd4, "b2b_count");

        applyStimulus(F0, BP, 10, 1'b1);
        expectLiteral(0, 32'h0, "midreset_data");
        expectLiteral(4, 32'd4, "midreset_no_pulse");
        repeat (2 * BP) tick();

`ifdef SWIPT_FRAME_RX_RESYNC_EN
        applyStimulus(F0, 17, -1, 1'b0);
        expectLiteral(4, 32'd5, "slow17_count");
        expectLiteral(0, 32'hA5C3, "slow17_data");
`else
        applyStimulus(F0, 19, 31, 1'b0);
        expectLiteral(6, 32'd5, "slow19_err_count");
        expectLiteral(1, 32'h1, "slow19_code");
`endif
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
